// File: rtl/periph_rr_slave_arbiter_if.sv
// Bus bundle between the per-PE address decoders, the per-slave round-robin
// arbiter and the peripheral slave it fronts.
//   slave  modport: arbiter view (takes master requests and slave responses,
//                   drives grants, forwarded request and routed responses)
//   master modport: environment view (PE decoders plus peripheral slave)
// Signal groups:
//   data_req_i/add_i/wen_i/wdata_i/be_i/ID_i   flattened per-master requests
//   data_gnt_o/r_valid_o/r_rdata_o/r_opc_o     per-master grant and response
//   data_req_o/add_o/wen_o/wdata_o/be_o        request forwarded to the slave
//   data_gnt_i/r_valid_i/r_rdata_i/r_opc_i     slave grant and response
//   err_o                                      sticky unsolicited-response flag
interface periph_rr_slave_arbiter_if #(
  parameter int unsigned N_MASTER   = 16,
  parameter int unsigned ID_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = 4
);
  logic [N_MASTER-1:0]            data_req_i;
  logic [N_MASTER*ADDR_WIDTH-1:0] data_add_i;
  logic [N_MASTER-1:0]            data_wen_i;
  logic [N_MASTER*DATA_WIDTH-1:0] data_wdata_i;
  logic [N_MASTER*BE_WIDTH-1:0]   data_be_i;
  logic [N_MASTER*ID_WIDTH-1:0]   data_ID_i;
  logic [N_MASTER-1:0]            data_gnt_o;
  logic [N_MASTER-1:0]            data_r_valid_o;
  logic [DATA_WIDTH-1:0]          data_r_rdata_o;
  logic                           data_r_opc_o;
  logic                           data_req_o;
  logic [ADDR_WIDTH-1:0]          data_add_o;
  logic                           data_wen_o;
  logic [DATA_WIDTH-1:0]          data_wdata_o;
  logic [BE_WIDTH-1:0]            data_be_o;
  logic                           data_gnt_i;
  logic                           data_r_valid_i;
  logic [DATA_WIDTH-1:0]          data_r_rdata_i;
  logic                           data_r_opc_i;
  logic                           err_o;

  modport slave (
    input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i,
    output data_gnt_o, data_r_valid_o, data_r_rdata_o, data_r_opc_o,
    output data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
    input  data_gnt_i, data_r_valid_i, data_r_rdata_i, data_r_opc_i,
    output err_o
  );

  modport master (
    output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i,
    input  data_gnt_o, data_r_valid_o, data_r_rdata_o, data_r_opc_o,
    input  data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
    output data_gnt_i, data_r_valid_i, data_r_rdata_i, data_r_opc_i,
    input  err_o
  );
endinterface

// File: rtl/periph_rr_slave_arbiter.sv
// Per-slave round-robin arbiter of the peripheral interconnect.
// Picks one of N_MASTER requesters per cycle starting from the round-robin
// pointer, forwards its request to the slave with zero latency, remembers the
// IDs of accepted requests in an in-order FIFO and steers each slave response
// back to the master that issued it.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    periph_rr_slave_arbiter_if.slave (master requests, slave port,
//          routed responses, sticky error flag)
module periph_rr_slave_arbiter #(
  parameter int unsigned N_MASTER        = 16,
  parameter int unsigned ID_WIDTH        = 16,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  periph_rr_slave_arbiter_if.slave    bus
);

  localparam int unsigned RR_W  = $clog2(N_MASTER);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [RR_W-1:0]     rr_q;
  logic [RR_W-1:0]     winner;
  logic                found;
  int unsigned         scan_idx;

  logic [ID_WIDTH-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic                err_q;

  logic                full;
  logic                hs;
  logic                pop;
  logic                unsolicited;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Scan starts at rr_q and wraps, so the first hit is the round-robin winner.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = 0;
    for (int unsigned i = 0; i < N_MASTER; i++) begin
      scan_idx = (32'(rr_q) + i) % N_MASTER;
      if (!found && bus.data_req_i[scan_idx]) begin
        found  = 1'b1;
        winner = RR_W'(scan_idx);
      end
    end
  end

  assign full        = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign bus.data_req_o = found & ~full;
  assign hs          = bus.data_req_o & bus.data_gnt_i;
  assign pop         = bus.data_r_valid_i & (count_q != '0);
  assign unsolicited = bus.data_r_valid_i & (count_q == '0);

  always_comb begin
    bus.data_add_o   = '0;
    bus.data_wen_o   = 1'b0;
    bus.data_wdata_o = '0;
    bus.data_be_o    = '0;
    if (found) begin
      bus.data_add_o   = bus.data_add_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
      bus.data_wen_o   = bus.data_wen_i[winner];
      bus.data_wdata_o = bus.data_wdata_i[winner*DATA_WIDTH +: DATA_WIDTH];
      bus.data_be_o    = bus.data_be_i[winner*BE_WIDTH +: BE_WIDTH];
    end
  end

  always_comb begin
    bus.data_gnt_o = '0;
    if (hs) bus.data_gnt_o[winner] = 1'b1;
  end

  // The stored ID is the one-hot master select, so it is the response steering mask.
  always_comb begin
    bus.data_r_valid_o = '0;
    if (pop) bus.data_r_valid_o = fifo_q[rd_ptr_q];
  end

  assign bus.data_r_rdata_o = bus.data_r_rdata_i;
  assign bus.data_r_opc_o   = bus.data_r_opc_i;
  assign bus.err_o          = err_q;

  always_ff @(posedge clk) begin
    if (hs) fifo_q[wr_ptr_q] <= bus.data_ID_i[winner*ID_WIDTH +: ID_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (hs) begin
        rr_q     <= (winner == RR_W'(N_MASTER - 1)) ? '0 : winner + 1'b1;
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({hs, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (unsolicited) err_q <= 1'b1;
    end
  end

endmodule
